// File: rtl/mlp_div_seq_20u_11u.sv
// mlp_div_seq_20u_11u
//
// Iterative restoring unsigned divider that undoes the MLP 9u x 11u multiply.
// It retires one quotient bit per enabled cycle, MSB first, and uses a
// start/done handshake.
//
// Build option: MLP_DIV_SAT_EN
//   defined   -> an overflowing quotient clamps dout to all ones and raises ovf
//   undefined -> dout is the low dout_WIDTH quotient bits (wrap) and ovf stays 0
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-low reset; takes priority over ce
//   ce     in   clock enable; when low, all state and outputs hold
//   start  in   request; sampled only in IDLE with ce=1
//   din0   in   dividend (din0_WIDTH), captured on the accepting edge
//   din1   in   divisor  (din1_WIDTH), captured on the accepting edge
//   busy   out  high in CALC and DONE
//   done   out  high while in DONE
//   dout   out  quotient (dout_WIDTH), valid while done, held until next accept
//   rem    out  remainder (din1_WIDTH), same validity as dout
//   ovf    out  quotient did not fit in dout_WIDTH bits
//   dbz    out  divide by zero
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring iteration per enabled cycle
// DONE  | results presented for one enabled cycle
module mlp_div_seq_20u_11u #(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned din0_WIDTH = 32'd20,
  parameter int unsigned din1_WIDTH = 32'd11,
  parameter int unsigned dout_WIDTH = 32'd9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dbz
);

  localparam int unsigned CW = $clog2(din0_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // r_dq starts as the dividend and fills with quotient bits from the LSB end,
  // so after din0_WIDTH shifts it holds the full quotient.
  logic [din0_WIDTH-1:0] r_dq;
  logic [din1_WIDTH-1:0] r_dvs;
  logic [din1_WIDTH:0]   r_rem_p;
  logic [CW-1:0]         r_cnt;
  logic [dout_WIDTH-1:0] r_dout;
  logic [din1_WIDTH-1:0] r_rem;
  logic                  r_ovf;
  logic                  r_dbz;

  logic                  w_accept;
  logic                  w_div_zero;
  logic                  w_last;
  logic [din1_WIDTH+1:0] w_trial;
  logic [din1_WIDTH+1:0] w_dvs_ext;
  logic                  w_ge;
  logic [din1_WIDTH+1:0] w_rem_full;
  logic [din0_WIDTH-1:0] w_dq_nxt;
  logic [dout_WIDTH-1:0] w_dout_nxt;
  logic                  w_ovf_nxt;
  logic                  w_unused;

  assign w_accept   = ce && (r_state == IDLE) && start;
  assign w_div_zero = (din1 == '0);
  assign w_last     = (r_cnt == CW'(din0_WIDTH - 1));

  // Restoring step: r' = {r, dividend MSB}; subtract when r' >= divisor.
  assign w_trial    = {r_rem_p, r_dq[din0_WIDTH-1]};
  assign w_dvs_ext  = {2'b00, r_dvs};
  assign w_ge       = (w_trial >= w_dvs_ext);
  assign w_rem_full = w_ge ? (w_trial - w_dvs_ext) : w_trial;
  assign w_dq_nxt   = {r_dq[din0_WIDTH-2:0], w_ge};

`ifdef MLP_DIV_SAT_EN
  logic w_hi_set;
  assign w_hi_set   = |w_dq_nxt[din0_WIDTH-1:dout_WIDTH];
  assign w_dout_nxt = w_hi_set ? {dout_WIDTH{1'b1}} : w_dq_nxt[dout_WIDTH-1:0];
  assign w_ovf_nxt  = w_hi_set;
`else
  assign w_dout_nxt = w_dq_nxt[dout_WIDTH-1:0];
  assign w_ovf_nxt  = 1'b0;
`endif

  // The partial remainder is always below the divisor, so the top bit of the
  // widened subtract result is never needed; ID is an instance tag only.
  assign w_unused = w_rem_full[din1_WIDTH+1] ^ (^ID);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else if (ce) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = w_div_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dq    <= '0;
      r_dvs   <= '0;
      r_rem_p <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_rem   <= '0;
      r_ovf   <= 1'b0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_dq    <= din0;
      r_dvs   <= din1;
      r_rem_p <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_dbz   <= 1'b0;
      // Divide by zero skips CALC entirely and publishes its fixed result.
      if (w_div_zero) begin
        r_dbz  <= 1'b1;
        r_dout <= {dout_WIDTH{1'b1}};
        r_rem  <= '0;
      end
    end else if (ce && (r_state == CALC)) begin
      r_dq    <= w_dq_nxt;
      r_rem_p <= w_rem_full[din1_WIDTH:0];
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_dout <= w_dout_nxt;
        r_rem  <= w_rem_full[din1_WIDTH-1:0];
        r_ovf  <= w_ovf_nxt;
      end
    end
  end

  assign busy = (r_state == CALC) || (r_state == DONE);
  assign done = (r_state == DONE);
  assign dout = r_dout;
  assign rem  = r_rem;
  assign ovf  = r_ovf;
  assign dbz  = r_dbz;

endmodule

// File: tb/tb_mlp_div_seq_20u_11u.sv
module tb_mlp_div_seq_20u_11u;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        start;
  logic [19:0] din0;
  logic [10:0] din1;
  logic        busy;
  logic        done;
  logic [8:0]  dout;
  logic [10:0] rem;
  logic        ovf;
  logic        dbz;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mlp_div_seq_20u_11u dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .start (start),
    .din0  (din0),
    .din1  (din1),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .rem   (rem),
    .ovf   (ovf),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division plus the output rules of each build.
  function automatic void model(input logic [19:0] a, input logic [10:0] b,
                                output logic [8:0] q, output logic [10:0] r,
                                output logic ov, output logic dz);
    int unsigned qf;
    int unsigned rf;
    if (b == 11'd0) begin
      q = 9'd511; r = 11'd0; ov = 1'b0; dz = 1'b1;
    end else begin
      qf = int'(a) / int'(b);
      rf = int'(a) % int'(b);
      r  = 11'(rf);
      dz = 1'b0;
`ifdef MLP_DIV_SAT_EN
      ov = (qf > 511);
      q  = ov ? 9'd511 : 9'(qf);
`else
      ov = 1'b0;
      q  = 9'(qf % 512);
`endif
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for IDLE, issues one request with ce=1 and returns the number of
  // edges from the request until done is seen (accept edge counts as 1).
  task automatic do_op(input logic [19:0] a, input logic [10:0] b, output int cyc);
    int guard;
    guard = 0;
    while (busy && guard < 50) begin
      tick();
      guard++;
    end
    din0  = a;
    din1  = b;
    start = 1'b1;
    cyc   = 0;
    do begin
      tick();
      cyc++;
      start = 1'b0;
    end while (!done && cyc < 100);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ce    = 1'b0;
    start = 1'b1;
    din0  = 20'd5;
    din1  = 11'd1;
    tick();
    tick();
    total_cnt++;
    if ({busy, done, ovf, dbz, dout, rem} !== '0)
      $display("FAIL reset_outputs: busy=%0b done=%0b ovf=%0b dbz=%0b dout=%0d rem=%0d, want all 0",
               busy, done, ovf, dbz, dout, rem);
    else pass_cnt++;
    start = 1'b0;
    reset = 1'b1;
    ce    = 1'b1;
    tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%0b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_vectors();
    logic [19:0] va [4] = '{20'd450000, 20'd450007, 20'd12345, 20'd1024};
    logic [10:0] vb [4] = '{11'd1500, 11'd1500, 11'd0, 11'd2};
    logic [8:0]  eq;
    logic [10:0] er;
    logic        eo, ez;
    int          cyc, elat;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], cyc);
      model(va[i], vb[i], eq, er, eo, ez);
      elat = (vb[i] == 11'd0) ? 1 : 21;
      total_cnt++;
      if (cyc !== elat) $display("FAIL vec%0d_latency: got %0d cycles want %0d", i, cyc, elat);
      else pass_cnt++;
      total_cnt++;
      if ({dout, rem, ovf, dbz} !== {eq, er, eo, ez})
        $display("FAIL vec%0d_result: dout=%0d rem=%0d ovf=%0b dbz=%0b want %0d %0d %0b %0b",
                 i, dout, rem, ovf, dbz, eq, er, eo, ez);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({done, busy} !== 2'b00) $display("FAIL vec%0d_done_pulse: done=%0b busy=%0b want 0 0", i, done, busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_dbz_hold();
    int cyc;
    do_op(20'd999, 11'd0, cyc);
    ce = 1'b0;
    tick();
    tick();
    tick();
    total_cnt++;
    if ({done, dbz, dout} !== {1'b1, 1'b1, 9'd511})
      $display("FAIL dbz_hold: done=%0b dbz=%0b dout=%0d want 1 1 511", done, dbz, dout);
    else pass_cnt++;
    ce = 1'b1;
    tick();
    total_cnt++;
    if (done !== 1'b0) $display("FAIL dbz_release: done=%0b want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    logic [8:0]  eq;
    logic [10:0] er;
    logic        eo, ez;
    int          cyc;
    model(20'd450000, 11'd1500, eq, er, eo, ez);
    din0  = 20'd450000;
    din1  = 11'd1500;
    start = 1'b1;
    ce    = 1'b1;
    cyc   = 0;
    do begin
      tick();
      cyc++;
      // A second request while busy must be ignored.
      start = (cyc == 3);
      if (cyc == 3) begin
        din0 = 20'd77;
        din1 = 11'd3;
      end
      ce = !(cyc >= 5 && cyc < 10);
    end while (!done && cyc < 100);
    total_cnt++;
    if (cyc !== 26) $display("FAIL stall_latency: got %0d cycles want 26", cyc);
    else pass_cnt++;
    total_cnt++;
    if ({dout, rem, ovf, dbz} !== {eq, er, eo, ez})
      $display("FAIL stall_result: dout=%0d rem=%0d ovf=%0b dbz=%0b want %0d %0d %0b %0b",
               dout, rem, ovf, dbz, eq, er, eo, ez);
    else pass_cnt++;
    start = 1'b0;
    ce    = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [8:0]  eq;
    logic [10:0] er;
    logic        eo, ez;
    int          cyc;
    din0  = 20'd777777;
    din1  = 11'd1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    total_cnt++;
    if ({busy, done, ovf, dbz, dout, rem} !== '0)
      $display("FAIL reset_mid: busy=%0b done=%0b ovf=%0b dbz=%0b dout=%0d rem=%0d, want all 0",
               busy, done, ovf, dbz, dout, rem);
    else pass_cnt++;
    for (int i = 0; i < 25; i++) begin
      tick();
      total_cnt++;
      if (done !== 1'b0) begin
        $display("FAIL reset_mid_no_done: done=%0b want 0 at cycle %0d", done, i);
        break;
      end else pass_cnt++;
    end
    do_op(20'd123456, 11'd789, cyc);
    model(20'd123456, 11'd789, eq, er, eo, ez);
    total_cnt++;
    if (cyc !== 21 || {dout, rem, ovf, dbz} !== {eq, er, eo, ez})
      $display("FAIL reset_mid_fresh: cyc=%0d dout=%0d rem=%0d ovf=%0b want 21 %0d %0d %0b",
               cyc, dout, rem, ovf, cyc == 0 ? 0 : eq, er, eo);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [19:0] a;
    logic [10:0] b;
    logic [8:0]  eq;
    logic [10:0] er;
    logic        eo, ez;
    int          cyc, sel;
    for (int i = 0; i < 40; i++) begin
      a   = 20'($urandom_range(0, 20'hFFFFF));
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 11'd0;
      else if (sel < 4)  b = 11'($urandom_range(1, 15));
      else               b = 11'($urandom_range(1, 2047));
      do_op(a, b, cyc);
      model(a, b, eq, er, eo, ez);
      total_cnt++;
      if (cyc !== ((b == 11'd0) ? 1 : 21) || {dout, rem, ovf, dbz} !== {eq, er, eo, ez})
        $display("FAIL rand%0d a=%0d b=%0d: cyc=%0d dout=%0d rem=%0d ovf=%0b dbz=%0b want dout=%0d rem=%0d ovf=%0b dbz=%0b",
                 i, a, b, cyc, dout, rem, ovf, dbz, eq, er, eo, ez);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  eq;
    logic [10:0] er;
    logic        eo, ez;
    int          cyc;
    do_op(20'd600000, 11'd1200, cyc);
    din0  = 20'd65535;
    din1  = 11'd255;
    start = 1'b1;
    tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL b2b_done_ignores_start: busy=%0b want 0", busy);
    else pass_cnt++;
    tick();
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%0b want 1", busy);
    else pass_cnt++;
    cyc = 0;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    model(20'd65535, 11'd255, eq, er, eo, ez);
    total_cnt++;
    if (cyc !== 20 || {dout, rem, ovf, dbz} !== {eq, er, eo, ez})
      $display("FAIL b2b_second: cyc=%0d dout=%0d rem=%0d want 20 %0d %0d", cyc, dout, rem, eq, er);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    ce    = 1'b1;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    test_reset();
    test_vectors();
    test_dbz_hold();
    test_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mlp_div_seq_20u_11u.md
# mlp_div_seq_20u_11u

Iterative unsigned divider that reverses the MLP datapath's 9u x 11u pipelined multiply. It takes a 20-bit product-domain value and an 11-bit factor, and returns the 9-bit quotient and the 11-bit remainder. It sits beside the multiplier instances, uses the same `ce` stall semantics, and serves normalisation and rescaling steps. It produces one quotient bit per enabled cycle and has a start/done handshake.

## Interface
- `ID`, 32'd1, instance tag; no functional effect.
- `din0_WIDTH`, 32'd20, dividend width.
- `din1_WIDTH`, 32'd11, divisor width; also the remainder width.
- `dout_WIDTH`, 32'd9, quotient output width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `ce`  in  1  clock enable. When low, all state, counters and outputs hold.
- `start`  in  1  request. Sampled only in IDLE with `ce`=1.
- `din0`  in  din0_WIDTH  dividend. Captured on the accepting edge.
- `din1`  in  din1_WIDTH  divisor. Captured on the accepting edge.
- `busy`  out  1  high in CALC and DONE.
- `done`  out  1  high while in DONE.
- `dout`  out  dout_WIDTH  quotient. Valid while `done`=1; held until the next accept.
- `rem`  out  din1_WIDTH  remainder. Same validity as `dout`.
- `ovf`  out  1  quotient did not fit in dout_WIDTH bits.
- `dbz`  out  1  divide by zero.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on `start`=1 with din1 != 0.
  - IDLE -> DONE on `start`=1 with din1 == 0.
  - CALC -> DONE after din0_WIDTH iterations.
  - DONE -> IDLE after one enabled cycle.
- Accept edge:
  - Dividend goes into a din0_WIDTH shift register.
  - Divisor is latched.
  - Partial remainder (din1_WIDTH+1 bits) is cleared.
  - Bit counter is cleared.
  - `ovf` and `dbz` are cleared.
- CALC iteration (restoring algorithm, MSB first):
  - Compute r' = {r, dividend MSB}. Shift the dividend left by 1.
  - If r' >= divisor: r = r' - divisor and shift in quotient bit 1. Otherwise r = r' and shift in 0.
- Full quotient is din0_WIDTH bits internally.
  - If any bit above dout_WIDTH-1 is set, `ovf`=1.
  - `dout` follows the saturation rule in Configuration.
- Divide by zero:
  - `dbz`=1, `dout`=all ones, `rem`=0, `ovf`=0.
  - No iterations are run.
- `start` is ignored in CALC and DONE. There is no queueing.
- `start` and `ce`=0 in the same cycle: the request is not accepted.

## Timing
- Reset (`reset`=0 at an edge) wins over `ce` and forces:
  - state IDLE;
  - `busy`, `done`, `ovf`, `dbz` = 0;
  - `dout`, `rem`, counter and all internal registers = 0.
- Reset mid-CALC aborts the operation. No `done` is produced.
- Normal latency with `ce` held high:
  - accept edge E; iterations on edges E+1..E+20; DONE entered at E+20.
  - `done` is high for exactly one cycle, between E+20 and E+21.
  - 21 cycles from `start` to `done`.
- Divide-by-zero latency: DONE entered at E; `done` high between E and E+1.
- Each `ce`=0 cycle extends CALC or DONE by one cycle. `done` stays high until an enabled edge.
- Minimum interval between accepts: din0_WIDTH+2 cycles (IDLE must be revisited).

## Configuration
- `MLP_DIV_SAT_EN` defined:
  - On overflow, `dout` clamps to 2^dout_WIDTH-1.
  - `ovf`=1.
- `MLP_DIV_SAT_EN` undefined:
  - `dout` is the low dout_WIDTH bits of the full quotient (wrap-around).
  - `ovf` is tied to 0.
- `rem` and all other behaviour are identical in both builds.

## Test plan
- din0=450000, din1=1500, `ce`=1 -> `done` 21 cycles after `start`; `dout`=300, `rem`=0, `ovf`=0, `dbz`=0.
- din0=450007, din1=1500 -> `dout`=300, `rem`=7.
- din0=12345, din1=0 -> `done` on the cycle after accept; `dbz`=1, `dout`=511, `rem`=0.
- din0=1024, din1=2:
  - SAT build -> `dout`=511, `ovf`=1.
  - Non-SAT build -> `dout`=0, `ovf`=0.
  - Both builds -> `rem`=0.
- `ce` low for 5 cycles mid-CALC, plus a second `start` pulse while busy -> `done` arrives 26 cycles after the first `start`; results match the unstalled run; the second `start` is ignored.
- `reset`=0 at iteration 10 -> next cycle: IDLE, all outputs 0; a fresh `start` completes normally.
